// File: rtl/wb_dpsram_ctrl.sv
// Wishbone classic slave mapping a 4 KiB window onto two 512x32 dual-port SRAM banks.
// Port 0 of each bank is used for writes only and port 1 for reads only; every output is registered.
module wb_dpsram_ctrl #(
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
    parameter int          READ_LAT  = 1,
    parameter logic [31:0] OOR_DATA  = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    input  logic        wb_we_i,
    input  logic [3:0]  wb_sel_i,
    input  logic [31:0] wb_adr_i,
    input  logic [31:0] wb_dat_i,
    output logic        wb_ack_o,
    output logic [31:0] wb_dat_o,
    output logic        o_csb0,
    output logic        o_web0,
    output logic [3:0]  o_wmask0,
    output logic [8:0]  o_waddr0,
    output logic [31:0] o_din0,
    output logic        o_csb1,
    output logic [8:0]  o_addr1,
    input  logic [31:0] i_dout1,
    output logic        o_csb0_1,
    output logic        o_web0_1,
    output logic [3:0]  o_wmask0_1,
    output logic [8:0]  o_waddr0_1,
    output logic [31:0] o_din0_1,
    output logic        o_csb1_1,
    output logic [8:0]  o_addr1_1,
    input  logic [31:0] i_dout1_1
);

    // Handshake: a request is cyc&stb seen in IDLE; ack is a one-cycle pulse and
    // cyc/stb are ignored while it is high. Dropping cyc mid-access aborts with no ack.
    typedef enum logic [2:0] {IDLE, WR, RD_ISSUE, RD_WAIT, ACK} state_t;

    state_t      state, state_d;
    logic [1:0]  cnt, cnt_d;
    logic        bank_q, bank_d;
    logic        ack_q, ack_d;
    logic [31:0] dat_q, dat_d;

    logic [1:0]  csb0_q, csb0_d;
    logic [1:0]  web0_q, web0_d;
    logic [1:0]  csb1_q, csb1_d;
    logic [3:0]  wmask_q [2];
    logic [3:0]  wmask_d [2];
    logic [8:0]  waddr_q [2];
    logic [8:0]  waddr_d [2];
    logic [31:0] din_q   [2];
    logic [31:0] din_d   [2];
    logic [8:0]  addr1_q [2];
    logic [8:0]  addr1_d [2];

    logic       hit;
    logic       req;
    logic       bank;
    logic [8:0] word;
    logic       unused_adr;

    assign hit        = (wb_adr_i[31:12] == BASE_ADDR[31:12]);
    assign req        = wb_cyc_i & wb_stb_i;
    assign bank       = wb_adr_i[11];
    assign word       = wb_adr_i[10:2];
    assign unused_adr = ^wb_adr_i[1:0];

    // SRAM controls are single-cycle pulses, so every cycle defaults them back to idle.
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        bank_d  = bank_q;
        ack_d   = 1'b0;
        dat_d   = dat_q;
        csb0_d  = 2'b11;
        web0_d  = 2'b11;
        csb1_d  = 2'b11;
        for (int i = 0; i < 2; i++) begin
            wmask_d[i] = 4'h0;
            waddr_d[i] = 9'h0;
            din_d[i]   = 32'h0;
            addr1_d[i] = 9'h0;
        end

        case (state)
            IDLE: begin
                if (req) begin
                    if (!hit) begin
                        ack_d   = 1'b1;
                        state_d = ACK;
                        if (!wb_we_i) dat_d = OOR_DATA;
                    end else if (wb_we_i) begin
                        bank_d        = bank;
                        csb0_d[bank]  = (wb_sel_i == 4'h0);
                        web0_d[bank]  = 1'b0;
                        wmask_d[bank] = wb_sel_i;
                        waddr_d[bank] = word;
                        din_d[bank]   = wb_dat_i;
                        state_d       = WR;
                    end else begin
                        bank_d        = bank;
                        csb1_d[bank]  = 1'b0;
                        addr1_d[bank] = word;
                        state_d       = RD_ISSUE;
                    end
                end
            end
            WR: begin
                if (!wb_cyc_i) begin
                    state_d = IDLE;
                end else begin
                    ack_d   = 1'b1;
                    state_d = ACK;
                end
            end
            RD_ISSUE: begin
                if (!wb_cyc_i) begin
                    state_d = IDLE;
                end else begin
                    cnt_d   = 2'(READ_LAT - 1);
                    state_d = RD_WAIT;
                end
            end
            RD_WAIT: begin
                if (!wb_cyc_i) begin
                    state_d = IDLE;
                end else if (cnt == 2'd0) begin
                    dat_d   = bank_q ? i_dout1_1 : i_dout1;
                    ack_d   = 1'b1;
                    state_d = ACK;
                end else begin
                    cnt_d = cnt - 2'd1;
                end
            end
            ACK:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state  <= IDLE;
            cnt    <= 2'd0;
            bank_q <= 1'b0;
            ack_q  <= 1'b0;
            dat_q  <= 32'h0;
            csb0_q <= 2'b11;
            web0_q <= 2'b11;
            csb1_q <= 2'b11;
            for (int i = 0; i < 2; i++) begin
                wmask_q[i] <= 4'h0;
                waddr_q[i] <= 9'h0;
                din_q[i]   <= 32'h0;
                addr1_q[i] <= 9'h0;
            end
        end else begin
            state  <= state_d;
            cnt    <= cnt_d;
            bank_q <= bank_d;
            ack_q  <= ack_d;
            dat_q  <= dat_d;
            csb0_q <= csb0_d;
            web0_q <= web0_d;
            csb1_q <= csb1_d;
            for (int i = 0; i < 2; i++) begin
                wmask_q[i] <= wmask_d[i];
                waddr_q[i] <= waddr_d[i];
                din_q[i]   <= din_d[i];
                addr1_q[i] <= addr1_d[i];
            end
        end
    end

    assign wb_ack_o   = ack_q;
    assign wb_dat_o   = dat_q;
    assign o_csb0     = csb0_q[0];
    assign o_web0     = web0_q[0];
    assign o_wmask0   = wmask_q[0];
    assign o_waddr0   = waddr_q[0];
    assign o_din0     = din_q[0];
    assign o_csb1     = csb1_q[0];
    assign o_addr1    = addr1_q[0];
    assign o_csb0_1   = csb0_q[1];
    assign o_web0_1   = web0_q[1];
    assign o_wmask0_1 = wmask_q[1];
    assign o_waddr0_1 = waddr_q[1];
    assign o_din0_1   = din_q[1];
    assign o_csb1_1   = csb1_q[1];
    assign o_addr1_1  = addr1_q[1];

endmodule

// File: doc/wb_dpsram_ctrl.md
Name: wb_dpsram_ctrl

Overview:
Wishbone classic slave that maps a 4 KiB window onto the two 512x32 dual-port SRAM macros (1RW port 0 used write-only, 1R port 1 used read-only). Sits directly downstream of the soc's data bus, which issues Wishbone cycles and consumes ack/data. The block owns all SRAM pin timing (chip selects, write masks, read-latency wait). The soc top therefore sees a plain bus slave.

Parameters:
BASE_ADDR, 32'h3000_0000, window base; must be 4 KiB aligned; match on adr_i[31:12]
READ_LAT, 1, cycles from the SRAM capture edge until dout is valid to sample (1..3)
OOR_DATA, 32'h0000_0000, read data returned for out-of-window accesses

Ports:
clk_i  in  1  single clock, all logic rising-edge
rst_ni  in  1  synchronous active-low reset
wb_cyc_i, wb_stb_i, wb_we_i  in  1 each  Wishbone classic request
wb_sel_i  in  4  byte enables
wb_adr_i  in  32  byte address
wb_dat_i  in  32  write data
wb_ack_o  out  1  single-cycle acknowledge, registered
wb_dat_o  out  32  read data, registered
o_csb0, o_web0  out  1 each  bank0 port0 chip select / write enable, active-low
o_wmask0  out  4  bank0 port0 byte write mask
o_waddr0  out  9  bank0 port0 word address
o_din0  out  32  bank0 port0 write data
o_csb1  out  1  bank0 port1 chip select, active-low
o_addr1  out  9  bank0 port1 word address
i_dout1  in  32  bank0 port1 read data
o_csb0_1, o_web0_1, o_wmask0_1, o_waddr0_1, o_din0_1, o_csb1_1, o_addr1_1, i_dout1_1: identical set for bank1

Behaviour:
- Decode: hit = adr_i[31:12]==BASE_ADDR[31:12]; bank = adr_i[11]; word = adr_i[10:2]; adr_i[1:0] ignored.
- All outputs are registered. Reset/idle values: all csb/web = 1, wmask = 0, addresses = 0, din = 0, wb_ack_o = 0, wb_dat_o = 0.
- FSM states: IDLE, WR, RD_ISSUE, RD_WAIT, ACK.
- IDLE: a request is cyc&stb sampled at edge N.
  - Miss: go to ACK, wb_ack_o=1 in cycle N+1. On a read, wb_dat_o=OOR_DATA. No SRAM pin toggles.
  - Write hit: at edge N, drive the selected bank's csb0=0, web0=0, waddr0=word, din0=dat_i, wmask0=sel_i; go to WR. If sel_i==0, csb0 stays 1 (no write), but the access still acks with the same timing.
  - Read hit: at edge N, drive the selected bank's csb1=0, addr1=word; go to RD_ISSUE.
- WR: at edge N+1 the SRAM captures. Controls return to idle values and wb_ack_o=1; go to ACK. Write latency: ack visible in cycle N+2.
- RD_ISSUE: at edge N+1, csb1 returns to 1; load the wait counter with READ_LAT-1; go to RD_WAIT.
- RD_WAIT: when the counter reaches 0, register wb_dat_o from the selected bank's dout1 and set wb_ack_o=1; go to ACK. Read latency: ack in cycle N+2+READ_LAT (cycle N+3 at default).
- ACK: wb_ack_o is high for exactly this one cycle. Next edge: ack=0, go to IDLE. cyc/stb are not sampled in ACK, so a master holding stb across ack gets a fresh access starting the cycle after.
- wb_dat_o holds its last value between reads; writes do not change it.
- Abort: cyc_i low in WR/RD_ISSUE/RD_WAIT returns the FSM to IDLE next edge, with controls idle and no ack. A write already driven at edge N still commits.
- Only one bank is ever selected; the other bank's pins stay at idle values.
- rst_ni=0 at any edge forces all idle values and IDLE regardless of state; an in-flight access is dropped with no ack.
- Read-after-write to the same word is coherent because accesses are serialized: the read issues at least 1 cycle after the write capture.

Test Plan:
- Reset: hold rst_ni=0 for 3 cycles mid read -> all csb/web=1, ack=0, dat_o=0; after release, an idle bus produces no SRAM activity.
- Write 0x3000_0804 data 0xA5A5_1234 sel 4'b1111 -> bank1: csb0_1=0, web0_1=0, waddr0_1=1, wmask0_1=F for one cycle; ack in cycle N+2; bank0 pins idle.
- Read 0x3000_0004 with the SRAM model returning 0xCAFE_F00D, READ_LAT=1 -> csb1=0, addr1=1 for one cycle; ack with dat_o=0xCAFE_F00D in cycle N+3. Repeat with READ_LAT=3 -> ack in N+5.
- Byte write sel 4'b0100 to word 5, then read word 5 -> wmask0=4'b0100; only byte 2 changed in the model. Write with sel=0 -> ack, no csb0 pulse.
- Out-of-window read 0x2000_0000 and write 0x3000_1000 -> ack in cycle N+1, dat_o=OOR_DATA, no SRAM pins toggle.
- Abort: drop cyc_i in RD_WAIT (READ_LAT=3) -> no ack, IDLE next cycle. A back-to-back write then read of the same address returns the new data.
